// File: rtl/mips_multicycle_control_if.sv
// Control/datapath signal bundle for the multicycle MIPS controller.
// master = controller side, slave = datapath side.
interface mips_multicycle_control_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_wr_ena;
    logic       ir_write;
    logic       mdr_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       imm_zext;
    logic [3:0] alu_ctrl;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  opcode, funct, zero,
        output pc_en, pc_src, iord, mem_wr_ena, ir_write, mdr_write, reg_write,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, imm_zext, alu_ctrl,
               illegal_op, state
    );

    modport slave (
        output opcode, funct, zero,
        input  pc_en, pc_src, iord, mem_wr_ena, ir_write, mdr_write, reg_write,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, imm_zext, alu_ctrl,
               illegal_op, state
    );
endinterface

// File: rtl/mips_multicycle_control.sv
// Main control FSM of the multicycle MIPS core: sequences fetch/decode/execute/
// memory/writeback and drives every datapath enable and mux select.
module mips_multicycle_control #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic                             clk,
    input  logic                             rstb,
    mips_multicycle_control_if.master        ctl
);
    typedef enum logic [3:0] {
        FETCH   = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
        MEMWB   = 4'd4,  MEMWR  = 4'd5,  RTEXE  = 4'd6,  RTWB   = 4'd7,
        BRANCH  = 4'd8,  ITEXE  = 4'd9,  ITWB   = 4'd10, JUMP   = 4'd11,
        JAL     = 4'd12, JR     = 4'd13, ILLEGAL = 4'd14
    } state_e;

    localparam logic [2:0] LAT = 3'(MEM_LAT);

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23, OP_SW   = 6'h2B;

    localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_JR  = 6'h08, F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22, F_AND = 6'h24, F_OR  = 6'h25, F_SLT = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR  = 4'b0001, ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110, ALU_SLT = 4'b0111, ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       wait_done;

    assign wait_done = (cnt_q == LAT);

    function automatic logic rt_alu_op(input logic [5:0] f);
        case (f)
            F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_SLL, F_SRL: rt_alu_op = 1'b1;
            default:                                        rt_alu_op = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] rt_alu_ctrl(input logic [5:0] f);
        case (f)
            F_SUB:   rt_alu_ctrl = ALU_SUB;
            F_AND:   rt_alu_ctrl = ALU_AND;
            F_OR:    rt_alu_ctrl = ALU_OR;
            F_SLT:   rt_alu_ctrl = ALU_SLT;
            F_SLL:   rt_alu_ctrl = ALU_SLL;
            F_SRL:   rt_alu_ctrl = ALU_SRL;
            default: rt_alu_ctrl = ALU_ADD;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Wait counter only runs in FETCH/MEMRD; every transition leaves it at 0.
    always_comb begin
        state_d = FETCH;
        cnt_d   = '0;
        case (state_q)
            FETCH: begin
                if (wait_done) state_d = DECODE;
                else begin
                    state_d = FETCH;
                    cnt_d   = cnt_q + 3'd1;
                end
            end
            DECODE: begin
                case (ctl.opcode)
                    OP_LW, OP_SW:                        state_d = MEMADR;
                    OP_RTYPE: begin
                        if (ctl.funct == F_JR)           state_d = JR;
                        else if (rt_alu_op(ctl.funct))   state_d = RTEXE;
                        else                             state_d = ILLEGAL;
                    end
                    OP_BEQ, OP_BNE:                      state_d = BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:   state_d = ITEXE;
                    OP_J:                                state_d = JUMP;
                    OP_JAL:                              state_d = JAL;
                    default:                             state_d = ILLEGAL;
                endcase
            end
            MEMADR: state_d = (ctl.opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD: begin
                if (wait_done) state_d = MEMWB;
                else begin
                    state_d = MEMRD;
                    cnt_d   = cnt_q + 3'd1;
                end
            end
            RTEXE:   state_d = RTWB;
            ITEXE:   state_d = ITWB;
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        ctl.pc_en      = 1'b0;
        ctl.pc_src     = 2'b00;
        ctl.iord       = 1'b0;
        ctl.mem_wr_ena = 1'b0;
        ctl.ir_write   = 1'b0;
        ctl.mdr_write  = 1'b0;
        ctl.reg_write  = 1'b0;
        ctl.reg_dst    = 2'b00;
        ctl.mem_to_reg = 2'b00;
        ctl.alu_src_a  = 2'b00;
        ctl.alu_src_b  = 2'b00;
        ctl.imm_zext   = 1'b0;
        ctl.alu_ctrl   = ALU_AND;
        ctl.illegal_op = 1'b0;
        case (state_q)
            FETCH: begin
                ctl.alu_src_b = 2'b01;
                ctl.alu_ctrl  = ALU_ADD;
                ctl.ir_write  = wait_done;
                ctl.pc_en     = wait_done;
            end
            DECODE: begin
                ctl.alu_src_b = 2'b11;
                ctl.alu_ctrl  = ALU_ADD;
            end
            MEMADR: begin
                ctl.alu_src_a = 2'b01;
                ctl.alu_src_b = 2'b10;
                ctl.alu_ctrl  = ALU_ADD;
            end
            MEMRD: begin
                ctl.iord      = 1'b1;
                ctl.mdr_write = wait_done;
            end
            MEMWB: begin
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = 2'b01;
            end
            MEMWR: begin
                ctl.iord       = 1'b1;
                ctl.mem_wr_ena = 1'b1;
            end
            RTEXE: begin
                ctl.alu_src_a = (ctl.funct == F_SLL || ctl.funct == F_SRL) ? 2'b10 : 2'b01;
                ctl.alu_ctrl  = rt_alu_ctrl(ctl.funct);
            end
            RTWB: begin
                ctl.reg_write = 1'b1;
                ctl.reg_dst   = 2'b01;
            end
            BRANCH: begin
                ctl.alu_src_a = 2'b01;
                ctl.alu_ctrl  = ALU_SUB;
                ctl.pc_src    = 2'b01;
                ctl.pc_en     = (ctl.opcode == OP_BNE) ? !ctl.zero : ctl.zero;
            end
            ITEXE: begin
                ctl.alu_src_a = 2'b01;
                ctl.alu_src_b = 2'b10;
                case (ctl.opcode)
                    OP_ANDI: ctl.alu_ctrl = ALU_AND;
                    OP_ORI:  ctl.alu_ctrl = ALU_OR;
                    OP_SLTI: ctl.alu_ctrl = ALU_SLT;
                    default: ctl.alu_ctrl = ALU_ADD;
                endcase
                ctl.imm_zext = (ctl.opcode == OP_ANDI || ctl.opcode == OP_ORI);
            end
            ITWB: ctl.reg_write = 1'b1;
            JUMP: begin
                ctl.pc_src = 2'b10;
                ctl.pc_en  = 1'b1;
            end
            JAL: begin
                ctl.pc_src     = 2'b10;
                ctl.pc_en      = 1'b1;
                ctl.reg_write  = 1'b1;
                ctl.reg_dst    = 2'b10;
                ctl.mem_to_reg = 2'b10;
            end
            JR: begin
                ctl.pc_src = 2'b11;
                ctl.pc_en  = 1'b1;
            end
            ILLEGAL: ctl.illegal_op = 1'b1;
            default: ;
        endcase
    end

    assign ctl.state = state_q;
endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed-vector bench for mips_multicycle_control at MEM_LAT = 1, 3 and 0.
module tb_mips_multicycle_control;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstb1 = 1'b0;
    logic rstb3 = 1'b0;
    logic rstb0 = 1'b0;

    mips_multicycle_control_if bus1 ();
    mips_multicycle_control_if bus3 ();
    mips_multicycle_control_if bus0 ();

    mips_multicycle_control #(.MEM_LAT(1)) dut1 (.clk(clk), .rstb(rstb1), .ctl(bus1.master));
    mips_multicycle_control #(.MEM_LAT(3)) dut3 (.clk(clk), .rstb(rstb3), .ctl(bus3.master));
    mips_multicycle_control #(.MEM_LAT(0)) dut0 (.clk(clk), .rstb(rstb0), .ctl(bus0.master));

    localparam int ADD = 2, SUB = 6, AND_ = 0, OR_ = 1, SLT = 7, SLL = 8, SRL = 9;

    typedef struct {
        int rstb; int op; int fn; int z;
        int st; int pe; int ps; int io; int mw; int irw; int mdw; int rw;
        int dst; int mtr; int asa; int asb; int zx; int alu; int ill;
    } vec_t;

    vec_t vecs[$];
    int   nerr = 0;
    int   nchk = 0;

    task automatic chk(input string nm, input int idx, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s step %0d: got %0d expected %0d", nm, idx, act, exp);
        end
    endtask

    task automatic row(input int r, input int op, input int fn, input int z,
                       input int st, input int pe, input int ps, input int io,
                       input int mw, input int irw, input int mdw, input int rw,
                       input int dst, input int mtr, input int asa, input int asb,
                       input int zx, input int alu, input int ill);
        vec_t v;
        v.rstb = r; v.op = op; v.fn = fn; v.z = z;
        v.st = st; v.pe = pe; v.ps = ps; v.io = io; v.mw = mw; v.irw = irw;
        v.mdw = mdw; v.rw = rw; v.dst = dst; v.mtr = mtr; v.asa = asa;
        v.asb = asb; v.zx = zx; v.alu = alu; v.ill = ill;
        vecs.push_back(v);
    endtask

    // Columns after inputs: st pe ps io mw irw mdw rw dst mtr asa asb zx alu ill
    task automatic fetch0(input int op, input int fn, input int z);
        row(1, op, fn, z, 0, 0,0,0,0,0,0,0, 0,0,0,1,0,ADD,0);
    endtask

    task automatic fd(input int op, input int fn, input int z);
        fetch0(op, fn, z);
        row(1, op, fn, z, 0, 1,0,0,0,1,0,0, 0,0,0,1,0,ADD,0);
        row(1, op, fn, z, 1, 0,0,0,0,0,0,0, 0,0,0,3,0,ADD,0);
    endtask

    task automatic rt(input int fn, input int asa, input int alu);
        fd(0, fn, 0);
        row(1, 0, fn, 0, 6, 0,0,0,0,0,0,0, 0,0,asa,0,0,alu,0);
        row(1, 0, fn, 0, 7, 0,0,0,0,0,0,1, 1,0,0,0,0,AND_,0);
    endtask

    task automatic it(input int op, input int alu, input int zx);
        fd(op, 0, 0);
        row(1, op, 0, 0, 9,  0,0,0,0,0,0,0, 0,0,1,2,zx,alu,0);
        row(1, op, 0, 0, 10, 0,0,0,0,0,0,1, 0,0,0,0,0,AND_,0);
    endtask

    task automatic br(input int op, input int z, input int pe);
        fd(op, 0, z);
        row(1, op, 0, z, 8, pe,1,0,0,0,0,0, 0,0,1,0,0,SUB,0);
    endtask

    task automatic build_table();
        row(0, 'h23, 0, 0, 0, 0,0,0,0,0,0,0, 0,0,0,1,0,ADD,0);
        row(0, 'h23, 0, 0, 0, 0,0,0,0,0,0,0, 0,0,0,1,0,ADD,0);
        // lw
        fd('h23, 0, 0);
        row(1, 'h23, 0, 0, 2, 0,0,0,0,0,0,0, 0,0,1,2,0,ADD,0);
        row(1, 'h23, 0, 0, 3, 0,0,1,0,0,0,0, 0,0,0,0,0,AND_,0);
        row(1, 'h23, 0, 0, 3, 0,0,1,0,0,1,0, 0,0,0,0,0,AND_,0);
        row(1, 'h23, 0, 0, 4, 0,0,0,0,0,0,1, 0,1,0,0,0,AND_,0);
        // sw
        fd('h2B, 0, 0);
        row(1, 'h2B, 0, 0, 2, 0,0,0,0,0,0,0, 0,0,1,2,0,ADD,0);
        row(1, 'h2B, 0, 0, 5, 0,0,1,1,0,0,0, 0,0,0,0,0,AND_,0);
        // R-type
        rt('h20, 1, ADD);
        rt('h00, 2, SLL);
        rt('h22, 1, SUB);
        rt('h02, 2, SRL);
        rt('h2A, 1, SLT);
        rt('h25, 1, OR_);
        // jr
        fd(0, 'h08, 0);
        row(1, 0, 'h08, 0, 13, 1,3,0,0,0,0,0, 0,0,0,0,0,AND_,0);
        // unsupported funct
        fd(0, 'h21, 0);
        row(1, 0, 'h21, 0, 14, 0,0,0,0,0,0,0, 0,0,0,0,0,AND_,1);
        // branches
        br('h04, 1, 1);
        br('h04, 0, 0);
        br('h05, 1, 0);
        br('h05, 0, 1);
        // I-type ALU
        it('h08, ADD, 0);
        it('h0C, AND_, 1);
        it('h0D, OR_, 1);
        it('h0A, SLT, 0);
        // j, jal
        fd('h02, 0, 0);
        row(1, 'h02, 0, 0, 11, 1,2,0,0,0,0,0, 0,0,0,0,0,AND_,0);
        fd('h03, 0, 0);
        row(1, 'h03, 0, 0, 12, 1,2,0,0,0,0,1, 2,2,0,0,0,AND_,0);
        // illegal opcode
        fd('h3F, 0, 0);
        row(1, 'h3F, 0, 0, 14, 0,0,0,0,0,0,0, 0,0,0,0,0,AND_,1);
        // reset during FETCH wait, then during MEMRD
        fetch0('h23, 0, 0);
        row(0, 'h23, 0, 0, 0, 0,0,0,0,0,0,0, 0,0,0,1,0,ADD,0);
        fd('h23, 0, 0);
        row(1, 'h23, 0, 0, 2, 0,0,0,0,0,0,0, 0,0,1,2,0,ADD,0);
        row(1, 'h23, 0, 0, 3, 0,0,1,0,0,0,0, 0,0,0,0,0,AND_,0);
        row(0, 'h23, 0, 0, 0, 0,0,0,0,0,0,0, 0,0,0,1,0,ADD,0);
        fd('h2B, 0, 0);
    endtask

    task automatic run_table();
        foreach (vecs[i]) begin
            @(negedge clk);
            rstb1       = vecs[i].rstb[0];
            bus1.opcode = 6'(vecs[i].op);
            bus1.funct  = 6'(vecs[i].fn);
            bus1.zero   = vecs[i].z[0];
            #1;
            chk("state",      i, int'(bus1.state),      vecs[i].st);
            chk("pc_en",      i, int'(bus1.pc_en),      vecs[i].pe);
            chk("pc_src",     i, int'(bus1.pc_src),     vecs[i].ps);
            chk("iord",       i, int'(bus1.iord),       vecs[i].io);
            chk("mem_wr_ena", i, int'(bus1.mem_wr_ena), vecs[i].mw);
            chk("ir_write",   i, int'(bus1.ir_write),   vecs[i].irw);
            chk("mdr_write",  i, int'(bus1.mdr_write),  vecs[i].mdw);
            chk("reg_write",  i, int'(bus1.reg_write),  vecs[i].rw);
            chk("reg_dst",    i, int'(bus1.reg_dst),    vecs[i].dst);
            chk("mem_to_reg", i, int'(bus1.mem_to_reg), vecs[i].mtr);
            chk("alu_src_a",  i, int'(bus1.alu_src_a),  vecs[i].asa);
            chk("alu_src_b",  i, int'(bus1.alu_src_b),  vecs[i].asb);
            chk("imm_zext",   i, int'(bus1.imm_zext),   vecs[i].zx);
            chk("alu_ctrl",   i, int'(bus1.alu_ctrl),   vecs[i].alu);
            chk("illegal_op", i, int'(bus1.illegal_op), vecs[i].ill);
        end
    endtask

    // lw at MEM_LAT=3: 2*3+5 = 11 cycles
    task automatic run_lat3_lw();
        int exp_st[11] = '{0, 0, 0, 0, 1, 2, 3, 3, 3, 3, 4};
        bus3.opcode = 6'h23;
        bus3.funct  = 6'h00;
        bus3.zero   = 1'b0;
        @(negedge clk);
        rstb3 = 1'b1;
        #1;
        for (int k = 0; k < 11; k++) begin
            if (k != 0) begin
                @(negedge clk);
                #1;
            end
            chk("lat3_state",     100 + k, int'(bus3.state),     exp_st[k]);
            chk("lat3_ir_write",  100 + k, int'(bus3.ir_write),  (k == 3)  ? 1 : 0);
            chk("lat3_mdr_write", 100 + k, int'(bus3.mdr_write), (k == 9)  ? 1 : 0);
            chk("lat3_reg_write", 100 + k, int'(bus3.reg_write), (k == 10) ? 1 : 0);
        end
        @(negedge clk);
        #1;
        chk("lat3_state", 111, int'(bus3.state), 0);
    endtask

    // MEM_LAT=0: FETCH is a single cycle, so the load strobes are up in reset
    task automatic run_lat0_jump();
        bus0.opcode = 6'h02;
        bus0.funct  = 6'h00;
        bus0.zero   = 1'b0;
        @(negedge clk);
        #1;
        chk("lat0_rst_state",    200, int'(bus0.state),     0);
        chk("lat0_rst_ir_write", 200, int'(bus0.ir_write),  1);
        chk("lat0_rst_pc_en",    200, int'(bus0.pc_en),     1);
        chk("lat0_rst_alu_b",    200, int'(bus0.alu_src_b), 1);
        @(negedge clk);
        rstb0 = 1'b1;
        #1;
        chk("lat0_state", 201, int'(bus0.state), 0);
        @(negedge clk);
        #1;
        chk("lat0_state", 202, int'(bus0.state), 1);
        @(negedge clk);
        #1;
        chk("lat0_state",  203, int'(bus0.state),  11);
        chk("lat0_pc_src", 203, int'(bus0.pc_src), 2);
        chk("lat0_pc_en",  203, int'(bus0.pc_en),  1);
        @(negedge clk);
        #1;
        chk("lat0_state", 204, int'(bus0.state), 0);
    endtask

    initial begin
        bus1.opcode = 6'h00;
        bus1.funct  = 6'h00;
        bus1.zero   = 1'b0;
        build_table();
        run_lat0_jump();
        run_lat3_lw();
        run_table();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
